// File: rtl/see_pkg.sv
// Shared types and defaults for the SEE cone vector checker.
// Holds the sequencer state encoding, run-mode constants and LFSR defaults.
package see_pkg;
   typedef enum logic [2:0] {IDLE, LAUNCH, SETTLE, SAMPLE, DONE} see_state_e;

   localparam logic MODE_EXH  = 1'b0;
   localparam logic MODE_LFSR = 1'b1;

   localparam logic [7:0] DEF_LFSR_SEED = 8'hA5;
   localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/see_vec_gen.sv
// Vector register for the cones: exhaustive up-counter or Galois LFSR.
// Updates one cycle after load/advance; the top paces it, so there is no backpressure.
module see_vec_gen
   import see_pkg::*;
#(
   parameter int               VEC_W     = 8,
   parameter logic [VEC_W-1:0] LFSR_SEED = VEC_W'(DEF_LFSR_SEED),
   parameter logic [VEC_W-1:0] LFSR_TAPS = VEC_W'(DEF_LFSR_TAPS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             advance,
   input  logic             mode,
   output logic [VEC_W-1:0] vec_o,
   output logic             last
);
   logic [VEC_W-1:0] vec_q, vec_d, vec_nxt;

   always_comb begin
      if (mode == MODE_LFSR) begin
         vec_nxt = (vec_q >> 1) ^ (vec_q[0] ? LFSR_TAPS : '0);
      end else begin
         vec_nxt = vec_q + VEC_W'(1);
      end
      // The LFSR sequence ends once the next step would wrap back to the seed.
      last = (mode == MODE_LFSR) ? (vec_nxt == LFSR_SEED) : (vec_q == '1);
      vec_d = vec_q;
      if (load) begin
         vec_d = (mode == MODE_LFSR) ? LFSR_SEED : '0;
      end else if (advance) begin
         vec_d = vec_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_q <= '0;
      end else begin
         vec_q <= vec_d;
      end
   end

   assign vec_o = vec_q;
endmodule

// File: rtl/see_cone_vector_checker.sv
// Drives vectors into a DUT cone and a golden cone, compares them after SETTLE_CYC cycles, and records the results.
// Each vector costs SETTLE_CYC+1 cycles; start is ignored while a run is in progress.
module see_cone_vector_checker
   import see_pkg::*;
#(
   parameter int               VEC_W      = 8,
   parameter int               SETTLE_CYC = 2,
   parameter int               CNT_W      = 16,
   parameter logic [VEC_W-1:0] LFSR_SEED  = VEC_W'(DEF_LFSR_SEED),
   parameter logic [VEC_W-1:0] LFSR_TAPS  = VEC_W'(DEF_LFSR_TAPS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   output logic [VEC_W-1:0] vec_o,
   input  logic             dut_i,
   input  logic             gold_i,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [VEC_W-1:0] first_fail_vec,
   output logic             first_fail_vld
);
   localparam int                SCNT_W    = 4;
   localparam logic [SCNT_W-1:0] SETTLE_LD = SCNT_W'(SETTLE_CYC - 1);

   see_state_e        state_q, state_d;
   logic [SCNT_W-1:0] scnt_q, scnt_d;
   logic              mode_q, mode_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  err_q, err_d;
   logic [VEC_W-1:0]  ffv_q, ffv_d;
   logic              ffvld_q, ffvld_d;
   logic              load, adv, last, gen_mode;

   assign load     = (state_q == IDLE) && start;
   // The generator sees the live mode input only while loading; afterwards the latched copy.
   assign gen_mode = (state_q == IDLE) ? mode : mode_q;

   see_vec_gen #(
      .VEC_W     (VEC_W),
      .LFSR_SEED (LFSR_SEED),
      .LFSR_TAPS (LFSR_TAPS)
   ) u_vec_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .advance (adv),
      .mode    (gen_mode),
      .vec_o   (vec_o),
      .last    (last)
   );

   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      mode_d  = mode_q;
      err_d   = err_q;
      ffv_d   = ffv_q;
      ffvld_d = ffvld_q;
      adv     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LAUNCH;
               mode_d  = mode;
               err_d   = '0;
               ffv_d   = '0;
               ffvld_d = 1'b0;
            end
         end
         LAUNCH: begin
            scnt_d  = SETTLE_LD;
            state_d = (SETTLE_CYC == 1) ? SAMPLE : SETTLE;
         end
         SETTLE: begin
            scnt_d = scnt_q - SCNT_W'(1);
            if (scnt_q == SCNT_W'(1)) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            if (dut_i != gold_i) begin
               if (err_q != '1) begin
                  err_d = err_q + CNT_W'(1);
               end
               if (!ffvld_q) begin
                  ffv_d   = vec_o;
                  ffvld_d = 1'b1;
               end
            end
            if (last) begin
               state_d = DONE;
            end else begin
               adv     = 1'b1;
               state_d = LAUNCH;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == LAUNCH) || (state_d == SETTLE) || (state_d == SAMPLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         scnt_q  <= '0;
         mode_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= '0;
         ffv_q   <= '0;
         ffvld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         scnt_q  <= scnt_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ffv_q   <= ffv_d;
         ffvld_q <= ffvld_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign err_count      = err_q;
   assign first_fail_vec = ffv_q;
   assign first_fail_vld = ffvld_q;
endmodule

// File: tb/tb_see_cone_vector_checker.sv
// Bench for see_cone_vector_checker: behavioural cones, a reference run model and a scoreboard popped on done.
module tb_see_cone_vector_checker;
   localparam int SETTLE = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [7:0]  vec_o;
   logic        dut_i, gold_i, busy, done;
   logic [15:0] err_count;
   logic [7:0]  ffv;
   logic        ffvld;
   int          cone_sel = 0;

   logic        start2 = 1'b0;
   logic        mode2 = 1'b0;
   logic [7:0]  vec2;
   logic        dut2, gold2, busy2, done2;
   logic [3:0]  err2;
   logic [7:0]  ffv2;
   logic        ffvld2;

   typedef struct {
      int          cycles;
      logic [15:0] err;
      logic [7:0]  ffv;
      logic        ffvld;
      logic [7:0]  last;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   function automatic logic gold_f(input int cone, input logic [7:0] v);
      if (cone == 2) return (v > 8'd55);
      return ^v;
   endfunction

   function automatic logic dut_f(input int cone, input logic [7:0] v);
      case (cone)
         1:       return (^v) ^ (v == 8'h2C);
         2:       return 1'b1;
         3:       return ~(^v);
         default: return ^v;
      endcase
   endfunction

   assign gold_i = gold_f(cone_sel, vec_o);
   assign dut_i  = dut_f(cone_sel, vec_o);
   assign gold2  = ^vec2;
   assign dut2   = ~(^vec2);

   see_cone_vector_checker #(.VEC_W(8), .SETTLE_CYC(SETTLE), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .vec_o(vec_o),
      .dut_i(dut_i), .gold_i(gold_i), .busy(busy), .done(done), .err_count(err_count),
      .first_fail_vec(ffv), .first_fail_vld(ffvld)
   );

   see_cone_vector_checker #(.VEC_W(8), .SETTLE_CYC(SETTLE), .CNT_W(4)) u_dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .vec_o(vec2),
      .dut_i(dut2), .gold_i(gold2), .busy(busy2), .done(done2), .err_count(err2),
      .first_fail_vec(ffv2), .first_fail_vld(ffvld2)
   );

   task automatic model_push(input logic m, input int cone, input int cnt_w);
      exp_t        e;
      logic [7:0]  v;
      logic [15:0] sat;
      int          n;
      sat     = 16'((1 << cnt_w) - 1);
      v       = m ? 8'hA5 : 8'h00;
      n       = m ? 255 : 256;
      e.err   = '0;
      e.ffv   = '0;
      e.ffvld = 1'b0;
      e.last  = '0;
      for (int i = 0; i < n; i++) begin
         if (gold_f(cone, v) !== dut_f(cone, v)) begin
            if (e.err < sat) e.err = e.err + 16'd1;
            if (!e.ffvld) begin
               e.ffv   = v;
               e.ffvld = 1'b1;
            end
         end
         e.last = v;
         if (m) v = {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
         else   v = v + 8'd1;
      end
      e.cycles = n * (SETTLE + 1) + 1;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (vec_o !== 8'h00) begin errors++; $display("FAIL rst_vec got %h exp 00", vec_o); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
      checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL rst_err got %0d exp 0", err_count); end
      checks++; if (ffv !== 8'h00 || ffvld !== 1'b0) begin errors++; $display("FAIL rst_ff got %h/%b exp 00/0", ffv, ffvld); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_idle();
      int bad;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || done !== 1'b0 || vec_o !== 8'h00) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet got %0d bad cycles exp 0", bad); end
   endtask

   task automatic run_check(input string name, input logic m, input int cone, input bit restart);
      exp_t       e;
      int         cyc, hold_bad, busy_bad, run_len;
      logic [7:0] prev;
      bit         saw_ea;
      cone_sel = cone;
      mode     = m;
      model_push(m, cone, 16);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mode  = ~m;
      cyc = 1; prev = vec_o; run_len = 0; hold_bad = 0; busy_bad = 0; saw_ea = 1'b0;
      while (done !== 1'b1 && cyc < 2000) begin
         if (busy !== 1'b1) busy_bad++;
         if (vec_o === prev) run_len++;
         else begin
            if (run_len != SETTLE + 1) hold_bad++;
            run_len = 1;
            prev    = vec_o;
         end
         if (vec_o == 8'hEA) saw_ea = 1'b1;
         start = restart && (cyc == 100);
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      e = sb_q.pop_front();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done_timeout got cyc %0d exp done", name, cyc); end
      checks++; if (cyc != e.cycles) begin errors++; $display("FAIL %s cycles got %0d exp %0d", name, cyc, e.cycles); end
      checks++; if (err_count !== e.err) begin errors++; $display("FAIL %s err_count got %0d exp %0d", name, err_count, e.err); end
      checks++; if (ffvld !== e.ffvld) begin errors++; $display("FAIL %s ff_vld got %b exp %b", name, ffvld, e.ffvld); end
      checks++; if (ffv !== e.ffv) begin errors++; $display("FAIL %s ff_vec got %h exp %h", name, ffv, e.ffv); end
      checks++; if (vec_o !== e.last) begin errors++; $display("FAIL %s last_vec got %h exp %h", name, vec_o, e.last); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b exp 0", name, busy); end
      checks++; if (hold_bad != 0) begin errors++; $display("FAIL %s vec_hold got %0d bad exp 0", name, hold_bad); end
      checks++; if (busy_bad != 0) begin errors++; $display("FAIL %s busy_in_run got %0d bad exp 0", name, busy_bad); end
      if (m) begin
         checks++; if (!saw_ea) begin errors++; $display("FAIL %s saw_EA got 0 exp 1", name); end
      end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse got %b exp 0", name, done); end
      @(posedge clk); #1;
      checks++; if (err_count !== e.err || ffvld !== e.ffvld) begin
         errors++; $display("FAIL %s idle_hold got %0d/%b exp %0d/%b", name, err_count, ffvld, e.err, e.ffvld);
      end
      mode = m;
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      bit saw_done;
      cone_sel = 1;
      mode     = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; saw_done = 1'b0;
      while (cyc < 300) begin
         if (done === 1'b1) saw_done = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (err_count !== 16'd1 || busy !== 1'b1) begin
         errors++; $display("FAIL midrst_pre got err %0d busy %b exp 1/1", err_count, busy);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
      checks++; if (vec_o !== 8'h00) begin errors++; $display("FAIL midrst_vec got %h exp 00", vec_o); end
      checks++; if (err_count !== 16'h0 || ffvld !== 1'b0) begin
         errors++; $display("FAIL midrst_res got %0d/%b exp 0/0", err_count, ffvld);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      checks++; if (saw_done) begin errors++; $display("FAIL midrst_nodone got 1 exp 0"); end
      run_check("after_rst", 1'b0, 1, 1'b0);
   endtask

   task automatic test_saturate();
      exp_t e;
      int   cyc;
      model_push(1'b0, 3, 4);
      @(posedge clk); #1;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      cyc = 1;
      while (done2 !== 1'b1 && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
      e = sb_q.pop_front();
      checks++; if (cyc != e.cycles) begin errors++; $display("FAIL sat_cycles got %0d exp %0d", cyc, e.cycles); end
      checks++; if (err2 !== e.err[3:0]) begin errors++; $display("FAIL sat_err got %0d exp %0d", err2, e.err[3:0]); end
      checks++; if (ffv2 !== e.ffv || ffvld2 !== e.ffvld) begin
         errors++; $display("FAIL sat_ff got %h/%b exp %h/%b", ffv2, ffvld2, e.ffv, e.ffvld);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      run_check("exh_clean", 1'b0, 0, 1'b0);
      run_check("exh_single", 1'b0, 1, 1'b0);
      run_check("lfsr_stuck1", 1'b1, 2, 1'b0);
      run_check("exh_restart", 1'b0, 1, 1'b1);
      test_reset_mid_run();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
